// File: rtl/ray_march_ctrl_pkg.sv
// Shared float format, controller state codes and the truncating float add/multiply helpers
// used by the ray-march controller and its step pipeline.
package ray_march_ctrl_pkg;

    typedef logic [26:0] fp_t;

    typedef struct packed {
        fp_t x;
        fp_t y;
        fp_t z;
    } vec3_t;

    localparam int unsigned SIGN_BIT = 26;
    localparam int unsigned EXP_HI   = 25;
    localparam int unsigned EXP_LO   = 18;

    localparam fp_t FP_ZERO    = 27'h0000000;
    localparam fp_t FP_ONE     = 27'h1fc0000;
    localparam fp_t FP_NEG_ONE = 27'h5fc0000;
    localparam fp_t FP_TWO     = 27'h2000000;
    localparam fp_t FP_NEG_TWO = 27'h6000000;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StIssue   = 3'd1;
    localparam logic [2:0] StWaitSdf = 3'd2;
    localparam logic [2:0] StEval    = 3'd3;
    localparam logic [2:0] StStep    = 3'd4;
    localparam logic [2:0] StDone    = 3'd5;

    function automatic fp_t fp_mul(input fp_t a, input fp_t b);
        logic        s;
        logic [37:0] p;
        logic [17:0] m;
        int          e;
        s = a[SIGN_BIT] ^ b[SIGN_BIT];
        if (a[EXP_HI:EXP_LO] == 8'd0 || b[EXP_HI:EXP_LO] == 8'd0) return {s, 26'd0};
        p = 38'({1'b1, a[17:0]}) * 38'({1'b1, b[17:0]});
        e = int'(a[EXP_HI:EXP_LO]) + int'(b[EXP_HI:EXP_LO]) - 127;
        if (p[37]) begin
            m = p[36:19];
            e = e + 1;
        end else begin
            m = p[35:18];
        end
        if (e <= 0) return {s, 26'd0};
        if (e >= 255) return {s, 8'hff, 18'd0};
        return {s, e[7:0], m};
    endfunction

    // Guard/round/sticky bits keep truncation exact for effective subtraction.
    function automatic fp_t fp_add(input fp_t a, input fp_t b);
        fp_t         l;
        fp_t         s;
        logic [21:0] ml;
        logic [21:0] ms;
        logic [22:0] sum;
        int          e;
        int          sh;
        if (b[EXP_HI:EXP_LO] == 8'd0) return (a[EXP_HI:EXP_LO] == 8'd0) ? FP_ZERO : a;
        if (a[EXP_HI:EXP_LO] == 8'd0) return b;
        if (a[25:0] >= b[25:0]) begin
            l = a;
            s = b;
        end else begin
            l = b;
            s = a;
        end
        sh = int'(l[EXP_HI:EXP_LO]) - int'(s[EXP_HI:EXP_LO]);
        ml = {1'b1, l[17:0], 3'b000};
        ms = {1'b1, s[17:0], 3'b000};
        for (int i = 0; i < 22; i++) begin
            if (i < sh) ms = {1'b0, ms[21:2], ms[1] | ms[0]};
        end
        e = int'(l[EXP_HI:EXP_LO]);
        if (l[SIGN_BIT] == s[SIGN_BIT]) sum = {1'b0, ml} + {1'b0, ms};
        else                            sum = {1'b0, ml} - {1'b0, ms};
        if (sum == 23'd0) return FP_ZERO;
        if (sum[22]) begin
            sum = {1'b0, sum[22:2], sum[1] | sum[0]};
            e   = e + 1;
        end
        for (int i = 0; i < 22; i++) begin
            if (!sum[21]) begin
                sum = sum << 1;
                e   = e - 1;
            end
        end
        if (e <= 0) return FP_ZERO;
        if (e >= 255) return {l[SIGN_BIT], 8'hff, 18'd0};
        return {l[SIGN_BIT], e[7:0], sum[20:3]};
    endfunction

endpackage

// File: rtl/ray_march_ctrl_step.sv
// ray_step_update: pipelined t_new = t + d and point_new = origin + dir * t_new,
// STEP_LATENCY cycles from i_start to o_done.
module ray_step_update
    import ray_march_ctrl_pkg::*;
#(
    parameter int unsigned STEP_LATENCY = 4
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  i_start,
    input  fp_t   i_t,
    input  fp_t   i_d,
    input  vec3_t i_origin,
    input  vec3_t i_dir,
    output logic  o_done,
    output fp_t   o_t_new,
    output vec3_t o_point_new
);

    typedef struct packed {
        logic  v;
        fp_t   t;
        vec3_t p;
    } stage_t;

    logic   v1_q, v2_q;
    fp_t    t1_q, t2_q;
    vec3_t  org1_q, dir1_q, org2_q, prod2_q;
    vec3_t  point_c;
    // Stage 3 onwards is a plain delay line padding the pipe out to STEP_LATENCY.
    stage_t tail_q [STEP_LATENCY-2];

    always_comb begin
        point_c.x = fp_add(org2_q.x, prod2_q.x);
        point_c.y = fp_add(org2_q.y, prod2_q.y);
        point_c.z = fp_add(org2_q.z, prod2_q.z);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            t1_q    <= '0;
            t2_q    <= '0;
            org1_q  <= '0;
            dir1_q  <= '0;
            org2_q  <= '0;
            prod2_q <= '0;
            for (int i = 0; i < int'(STEP_LATENCY) - 2; i++) tail_q[i] <= '0;
        end else begin
            v1_q      <= i_start;
            t1_q      <= fp_add(i_t, i_d);
            org1_q    <= i_origin;
            dir1_q    <= i_dir;
            v2_q      <= v1_q;
            t2_q      <= t1_q;
            org2_q    <= org1_q;
            prod2_q.x <= fp_mul(dir1_q.x, t1_q);
            prod2_q.y <= fp_mul(dir1_q.y, t1_q);
            prod2_q.z <= fp_mul(dir1_q.z, t1_q);
            tail_q[0] <= '{v: v2_q, t: t2_q, p: point_c};
            for (int i = 1; i < int'(STEP_LATENCY) - 2; i++) tail_q[i] <= tail_q[i-1];
        end
    end

    assign o_done      = tail_q[STEP_LATENCY-3].v;
    assign o_t_new     = tail_q[STEP_LATENCY-3].t;
    assign o_point_new = tail_q[STEP_LATENCY-3].p;

endmodule

// File: rtl/ray_march_ctrl.sv
// Single-ray sphere-tracing controller: issues sample points to the sdf pipe, evaluates the
// returned distance, advances the ray and reports hit/miss with step count and distance.
module ray_march_ctrl
    import ray_march_ctrl_pkg::*;
#(
    parameter int unsigned SDF_LATENCY  = 10,
    parameter int unsigned STEP_LATENCY = 4,
    parameter logic [26:0] EPSILON      = 27'h1d41893,
    parameter logic [26:0] MAX_DIST     = 27'h2140000,
    parameter int unsigned MAX_STEPS    = 64,
    parameter int unsigned ID_W         = 19
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_ray_valid,
    output logic            o_ray_ready,
    input  logic [26:0]     i_origin_x,
    input  logic [26:0]     i_origin_y,
    input  logic [26:0]     i_origin_z,
    input  logic [26:0]     i_dir_x,
    input  logic [26:0]     i_dir_y,
    input  logic [26:0]     i_dir_z,
    input  logic [ID_W-1:0] i_pixel,
    output logic [26:0]     o_sdf_point_x,
    output logic [26:0]     o_sdf_point_y,
    output logic [26:0]     o_sdf_point_z,
    output logic            o_sdf_issue,
    input  logic [26:0]     i_sdf_distance,
    output logic            o_res_valid,
    input  logic            i_res_ready,
    output logic            o_hit,
    output logic [7:0]      o_steps,
    output logic [26:0]     o_t,
    output logic [ID_W-1:0] o_pixel
);

    logic [2:0]      state_q, state_d;
    vec3_t           org_q, org_d, dir_q, dir_d, point_q, point_d;
    fp_t             t_q, t_d, d_q, d_d;
    logic [7:0]      steps_q, steps_d, cnt_q, cnt_d;
    logic            hit_q, hit_d;
    logic [ID_W-1:0] pixel_q, pixel_d;

    fp_t   t_sum_c;
    logic  hit_c, stop_c, start_c, upd_done;
    fp_t   upd_t;
    vec3_t upd_point;

    ray_step_update #(
        .STEP_LATENCY(STEP_LATENCY)
    ) u_step (
        .clk        (clk),
        .reset      (reset),
        .i_start    (start_c),
        .i_t        (t_q),
        .i_d        (d_q),
        .i_origin   (org_q),
        .i_dir      (dir_q),
        .o_done     (upd_done),
        .o_t_new    (upd_t),
        .o_point_new(upd_point)
    );

    // EVAL shares the adder result with the miss path so a miss reports t+d.
    assign t_sum_c = fp_add(t_q, d_q);
    assign hit_c   = d_q[26] || (d_q[25:0] < EPSILON[25:0]);
    assign stop_c  = ({1'b0, steps_q} + 9'd1 == 9'(MAX_STEPS)) ||
                     (!t_sum_c[26] && (t_sum_c[25:0] > MAX_DIST[25:0]));

    always_comb begin
        state_d = state_q;
        org_d   = org_q;
        dir_d   = dir_q;
        point_d = point_q;
        t_d     = t_q;
        d_d     = d_q;
        steps_d = steps_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        pixel_d = pixel_q;
        start_c = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_ray_valid) begin
                    org_d   = '{x: i_origin_x, y: i_origin_y, z: i_origin_z};
                    dir_d   = '{x: i_dir_x, y: i_dir_y, z: i_dir_z};
                    point_d = '{x: i_origin_x, y: i_origin_y, z: i_origin_z};
                    pixel_d = i_pixel;
                    t_d     = FP_ZERO;
                    steps_d = 8'd0;
                    hit_d   = 1'b0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = 8'(SDF_LATENCY);
                state_d = StWaitSdf;
            end
            StWaitSdf: begin
                if (cnt_q == 8'd1) begin
                    d_d     = i_sdf_distance;
                    state_d = StEval;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StEval: begin
                if (hit_c) begin
                    hit_d   = 1'b1;
                    state_d = StDone;
                end else if (stop_c) begin
                    t_d     = t_sum_c;
                    steps_d = steps_q + 8'd1;
                    state_d = StDone;
                end else begin
                    start_c = 1'b1;
                    state_d = StStep;
                end
            end
            StStep: begin
                if (upd_done) begin
                    t_d     = upd_t;
                    point_d = upd_point;
                    steps_d = steps_q + 8'd1;
                    state_d = StIssue;
                end
            end
            StDone: begin
                if (i_res_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            org_q   <= '0;
            dir_q   <= '0;
            point_q <= '0;
            t_q     <= '0;
            d_q     <= '0;
            steps_q <= '0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            pixel_q <= '0;
        end else begin
            state_q <= state_d;
            org_q   <= org_d;
            dir_q   <= dir_d;
            point_q <= point_d;
            t_q     <= t_d;
            d_q     <= d_d;
            steps_q <= steps_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            pixel_q <= pixel_d;
        end
    end

    assign o_ray_ready   = (state_q == StIdle) && !reset;
    assign o_sdf_issue   = (state_q == StIssue);
    assign o_res_valid   = (state_q == StDone);
    assign o_sdf_point_x = point_q.x;
    assign o_sdf_point_y = point_q.y;
    assign o_sdf_point_z = point_q.z;
    assign o_hit         = hit_q;
    assign o_steps       = steps_q;
    assign o_t           = t_q;
    assign o_pixel       = pixel_q;

endmodule

// File: tb/tb_ray_march_ctrl.sv
// Randomized bench for ray_march_ctrl: a sdf stand-in answering at the fixed latency and a
// real-arithmetic sphere-tracing model predicting sample points and results.
module tb_ray_march_ctrl;

    localparam int unsigned SDF_LAT  = 10;
    localparam int unsigned STEP_LAT = 4;
    localparam int unsigned MAXS     = 64;
    localparam int unsigned ID_W     = 19;
    localparam logic [26:0] EPS      = 27'h1d41893;
    localparam logic [26:0] MAXD     = 27'h2140000;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            i_ray_valid = 1'b0;
    logic            o_ray_ready;
    logic [26:0]     i_origin_x = '0, i_origin_y = '0, i_origin_z = '0;
    logic [26:0]     i_dir_x = '0, i_dir_y = '0, i_dir_z = '0;
    logic [ID_W-1:0] i_pixel = '0;
    logic [26:0]     o_sdf_point_x, o_sdf_point_y, o_sdf_point_z;
    logic            o_sdf_issue;
    logic [26:0]     i_sdf_distance = '0;
    logic            o_res_valid;
    logic            i_res_ready = 1'b0;
    logic            o_hit;
    logic [7:0]      o_steps;
    logic [26:0]     o_t;
    logic [ID_W-1:0] o_pixel;

    always #5 clk = ~clk;

    ray_march_ctrl #(
        .SDF_LATENCY (SDF_LAT),
        .STEP_LATENCY(STEP_LAT),
        .EPSILON     (EPS),
        .MAX_DIST    (MAXD),
        .MAX_STEPS   (MAXS),
        .ID_W        (ID_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_ray_valid   (i_ray_valid),
        .o_ray_ready   (o_ray_ready),
        .i_origin_x    (i_origin_x),
        .i_origin_y    (i_origin_y),
        .i_origin_z    (i_origin_z),
        .i_dir_x       (i_dir_x),
        .i_dir_y       (i_dir_y),
        .i_dir_z       (i_dir_z),
        .i_pixel       (i_pixel),
        .o_sdf_point_x (o_sdf_point_x),
        .o_sdf_point_y (o_sdf_point_y),
        .o_sdf_point_z (o_sdf_point_z),
        .o_sdf_issue   (o_sdf_issue),
        .i_sdf_distance(i_sdf_distance),
        .o_res_valid   (o_res_valid),
        .i_res_ready   (i_res_ready),
        .o_hit         (o_hit),
        .o_steps       (o_steps),
        .o_t           (o_t),
        .o_pixel       (o_pixel)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic real f2r(input logic [26:0] f);
        real m;
        int  e;
        if (f[25:18] == 8'd0) return 0.0;
        m = 1.0 + real'(f[17:0]) / 262144.0;
        e = int'(f[25:18]) - 127;
        if (e >= 0) repeat (e) m = m * 2.0;
        else        repeat (-e) m = m / 2.0;
        return f[26] ? -m : m;
    endfunction

    // Truncating conversion: round toward zero.
    function automatic logic [26:0] r2f(input real r);
        real         a;
        int          e;
        logic        s;
        logic [17:0] m;
        if (r == 0.0) return 27'd0;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 127;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        m = 18'($rtoi((a - 1.0) * 262144.0));
        return {s, 8'(e), m};
    endfunction

    function automatic logic [26:0] ref_axis(input logic [26:0] o, input logic [26:0] dr,
                                             input real t);
        return r2f(f2r(o) + f2r(r2f(f2r(dr) * t)));
    endfunction

    logic [26:0] dists [MAXS];
    logic [26:0] dir_tab [9];
    logic [26:0] d_tab [10];
    logic [80:0] exp_pts [$];
    logic [80:0] got_pts [$];
    logic        exp_hit;
    int          exp_steps;
    logic [26:0] exp_t;
    logic [ID_W-1:0] exp_pix;
    int          cur_mode;
    int          cyc = 0;
    int          n_issue = 0;
    int          issue_cyc = 0;
    bit          pend = 0;

    logic [26:0] spec_t [4];
    int          spec_steps [4];
    logic        spec_hit [4];

    always @(posedge clk) cyc <= cyc + 1;

    // sdf stand-in: valid distance only in the exact capture cycle, junk otherwise.
    always @(negedge clk) begin
        if (reset) begin
            pend = 0;
        end else if (o_sdf_issue) begin
            pend      = 1;
            issue_cyc = cyc;
            n_issue++;
            got_pts.push_back({o_sdf_point_x, o_sdf_point_y, o_sdf_point_z});
        end
        if (pend && cyc == issue_cyc + int'(SDF_LAT)) begin
            check_eq("point_stable", {o_sdf_point_x, o_sdf_point_y, o_sdf_point_z}, got_pts[$]);
            i_sdf_distance = (n_issue <= int'(MAXS)) ? dists[n_issue-1] : 27'($urandom);
            pend = 0;
        end else begin
            i_sdf_distance = 27'($urandom);
        end
    end

    task automatic start_ray(input int mode);
        logic [26:0] org [3];
        logic [26:0] dr [3];
        logic [26:0] d;
        real         t;
        int          k;
        cur_mode = mode;
        for (int i = 0; i < 3; i++) begin
            org[i] = r2f(real'($urandom_range(16)) - 8.0);
            dr[i]  = dir_tab[$urandom_range(8)];
        end
        exp_pix = ID_W'($urandom);
        for (int i = 0; i < int'(MAXS); i++) begin
            case (mode)
                0:       dists[i] = 27'h1f80000;
                1:       dists[i] = (i < 3) ? 27'h1fc0000 : 27'h0;
                2:       dists[i] = 27'h5fc0000;
                3:       dists[i] = 27'h20c0000;
                default: dists[i] = d_tab[$urandom_range(9)];
            endcase
        end
        t = 0.0;
        exp_steps = 0;
        exp_hit = 1'b0;
        exp_pts.delete();
        for (int it = 0; it < int'(MAXS); it++) begin
            exp_pts.push_back({ref_axis(org[0], dr[0], t), ref_axis(org[1], dr[1], t),
                               ref_axis(org[2], dr[2], t)});
            d = dists[it];
            if (d[26] || f2r(d) < f2r(EPS)) begin
                exp_hit = 1'b1;
                break;
            end
            t = f2r(r2f(t + f2r(d)));
            exp_steps++;
            if (exp_steps == int'(MAXS) || t > f2r(MAXD)) break;
        end
        exp_t = r2f(t);

        pend = 0;
        n_issue = 0;
        got_pts.delete();
        k = 0;
        while (!o_ray_ready && k < 100) begin @(negedge clk); k++; end
        check_eq("ready_before_ray", o_ray_ready, 1);
        i_origin_x  = org[0]; i_origin_y = org[1]; i_origin_z = org[2];
        i_dir_x     = dr[0];  i_dir_y    = dr[1];  i_dir_z    = dr[2];
        i_pixel     = exp_pix;
        i_ray_valid = 1'b1;
        @(negedge clk);
        i_ray_valid = 1'b0;
        i_origin_x  = 27'($urandom); i_dir_x = 27'($urandom); i_pixel = ID_W'($urandom);
    endtask

    task automatic finish_ray(input int hold);
        int k;
        k = 0;
        while (!o_res_valid && k < 20000) begin @(negedge clk); k++; end
        check_eq("res_valid_seen", o_res_valid, 1);
        for (int i = 0; i < hold; i++) begin
            check_eq("hold_outputs", {o_hit, o_steps, o_t, o_pixel, o_ray_ready, o_res_valid},
                     {exp_hit, 8'(exp_steps), exp_t, exp_pix, 1'b0, 1'b1});
            @(negedge clk);
        end
        check_eq("hit", o_hit, exp_hit);
        check_eq("steps", o_steps, exp_steps);
        check_eq("t", o_t, exp_t);
        check_eq("pixel", o_pixel, exp_pix);
        check_eq("ready_in_done", o_ray_ready, 0);
        check_eq("issue_count", n_issue, exp_pts.size());
        for (int i = 0; i < exp_pts.size() && i < got_pts.size(); i++)
            check_eq("sample_point", got_pts[i], exp_pts[i]);
        if (cur_mode < 4) begin
            check_eq("known_t", o_t, spec_t[cur_mode]);
            check_eq("known_steps", o_steps, spec_steps[cur_mode]);
            check_eq("known_hit", o_hit, spec_hit[cur_mode]);
        end
        // A ray offered during the result handshake must not be taken in that cycle.
        i_res_ready = 1'b1;
        i_ray_valid = 1'b1;
        @(negedge clk);
        i_res_ready = 1'b0;
        i_ray_valid = 1'b0;
        check_eq("valid_after_take", o_res_valid, 0);
        check_eq("ready_after_take", o_ray_ready, 1);
        check_eq("no_issue_after_take", o_sdf_issue, 0);
    endtask

    task automatic run_ray(input int mode, input int hold);
        start_ray(mode);
        finish_ray(hold);
    endtask

    initial begin
        int k;
        spec_t     = '{27'h2100000, 27'h2020000, 27'h0, 27'h2150000};
        spec_steps = '{64, 3, 0, 5};
        spec_hit   = '{1'b0, 1'b1, 1'b1, 1'b0};
        dir_tab[0] = 27'h0;
        dir_tab[1] = r2f(0.5);  dir_tab[2] = r2f(-0.5);
        dir_tab[3] = r2f(0.6);  dir_tab[4] = r2f(-0.6);
        dir_tab[5] = r2f(0.8);  dir_tab[6] = r2f(-0.8);
        dir_tab[7] = r2f(1.0);  dir_tab[8] = r2f(-1.0);
        d_tab[0] = r2f(0.25); d_tab[1] = r2f(0.5); d_tab[2] = r2f(1.0);
        d_tab[3] = r2f(2.0);  d_tab[4] = r2f(4.0); d_tab[5] = r2f(8.0);
        d_tab[6] = r2f(1.0 / 1024.0);
        d_tab[7] = r2f(-2.0);
        d_tab[8] = EPS;
        d_tab[9] = EPS - 27'd1;
        for (int i = 0; i < int'(MAXS); i++) dists[i] = 27'h1f80000;

        repeat (3) @(negedge clk);
        check_eq("rst_outputs",
                 {o_ray_ready, o_res_valid, o_sdf_issue, o_hit, o_steps, o_t, o_pixel},
                 {1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 27'd0, {ID_W{1'b0}}});
        check_eq("rst_point", {o_sdf_point_x, o_sdf_point_y, o_sdf_point_z}, 81'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", o_ray_ready, 1);

        run_ray(0, 2);
        run_ray(1, 0);
        run_ray(2, 1);
        run_ray(3, 0);
        run_ray(4, 20);
        for (int i = 0; i < 8; i++) run_ray(4, int'($urandom_range(3)));

        // Abort a ray while it waits on the sdf pipe.
        start_ray(0);
        k = 0;
        while (n_issue < 2 && k < 500) begin @(negedge clk); k++; end
        check_eq("abort_reached_issue2", n_issue, 2);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort_outputs", {o_res_valid, o_sdf_issue, o_ray_ready}, 3'b000);
        reset = 1'b0;
        @(negedge clk);
        check_eq("abort_ready", {o_ray_ready, o_res_valid}, 2'b10);
        run_ray(0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, tests %0d, failed %0d",
                 tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
